aes_kat_sequencer: RTL and testbench

Clocked known-answer-test controller for the combinational AES cores (key expansion, encrypt, decrypt) at 128/192/256-bit key lengths. On a start pulse it steps through the enabled key sizes. For each size it drives the FIPS-197 key and plaintext, waits a programmable settle time, captures and checks the ciphertext, feeds the captured ciphertext back to the decryptor, then checks the recovered plaintext. It sits between the top-level enable/LED logic and the three core chains. The top level muxes core results by `len_sel_o`.

---
 rtl/aes_kat_pkg.sv | 61 ++++++
 rtl/aes_kat_sequencer_if.sv | 40 ++++
 rtl/aes_kat_rom.sv | 37 +++
 rtl/aes_kat_sequencer.sv | 175 +++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_kat_pkg.sv
// aes_kat_pkg
// Shared types and constants for the AES known-answer-test sequencer.
// Contents:
//   KEY_W/BLK_W/LEN_W/CNT_W  bus widths (256-bit key, 128-bit block,
//                            2-bit key-size select, 8-bit settle counter)
//   kat_state_e              sequencer FSM states
//   LEN_128/LEN_192/LEN_256  key-size encodings carried on len_sel_o
//   KAT_PT, KAT_KEY, KAT_CT  FIPS-197 Appendix C vectors
//   next_enabled()           finds the next key size enabled by a mask
package aes_kat_pkg;

  localparam int unsigned KEY_W = 256;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned LEN_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ENC_WAIT,
    ST_ENC_CHK,
    ST_DEC_WAIT,
    ST_DEC_CHK,
    ST_DONE
  } kat_state_e;

  localparam logic [LEN_W-1:0] LEN_128 = 2'd0;
  localparam logic [LEN_W-1:0] LEN_192 = 2'd1;
  localparam logic [LEN_W-1:0] LEN_256 = 2'd2;

  localparam logic [BLK_W-1:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  // Keys are left-aligned so every core chain can take the same 256-bit bus;
  // the shorter keys leave their unused low bits at zero.
  localparam logic [KEY_W-1:0] KAT_KEY [3] = '{
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
    256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000,
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
  };

  localparam logic [BLK_W-1:0] KAT_CT [3] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'hdda97ca4864cdfe06eaf70a0ec0d7191,
    128'h8ea2b7ca516745bfeafc49904b496089
  };

  // Returns {found, index} for the lowest enabled size whose index is at
  // least 'from'. Passing from=3 therefore always reports "none left".
  function automatic logic [2:0] next_enabled(input logic [2:0] mask,
                                              input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_kat_sequencer_if.sv
// aes_kat_sequencer_if
// Bundles the sequencer's control and data bus towards the top-level
// enable/LED logic and the three AES core chains.
//   start_i    start pulse from the enable logic
//   enc_res_i  ciphertext from the encryptor selected by len_sel_o
//   dec_res_i  plaintext from the decryptor selected by len_sel_o
//   len_sel_o  current key size (0=128, 1=192, 2=256)
//   key_o      left-aligned key to the key expansion
//   blk_o      plaintext to the encryptor
//   ct_hold_o  captured ciphertext to the decryptor
//   busy_o     run in progress
//   done_o     one-cycle end-of-run pulse
//   pass_o     per-size pass flags
//   fail_o     per-size fail flags
// modport master: the sequencer; modport slave: cores and enable/LED logic.
interface aes_kat_sequencer_if import aes_kat_pkg::*; ();

  logic             start_i;
  logic [BLK_W-1:0] enc_res_i;
  logic [BLK_W-1:0] dec_res_i;
  logic [LEN_W-1:0] len_sel_o;
  logic [KEY_W-1:0] key_o;
  logic [BLK_W-1:0] blk_o;
  logic [BLK_W-1:0] ct_hold_o;
  logic             busy_o;
  logic             done_o;
  logic [2:0]       pass_o;
  logic [2:0]       fail_o;

  modport master (
    input  start_i, enc_res_i, dec_res_i,
    output len_sel_o, key_o, blk_o, ct_hold_o, busy_o, done_o, pass_o, fail_o
  );

  modport slave (
    output start_i, enc_res_i, dec_res_i,
    input  len_sel_o, key_o, blk_o, ct_hold_o, busy_o, done_o, pass_o, fail_o
  );

endinterface

// File: rtl/aes_kat_rom.sv
// aes_kat_rom
// Combinational lookup of the known-answer vectors for one key size.
//   len_sel_i  key size (0=128, 1=192, 2=256); code 3 returns zeros
//   key_o      left-aligned key for that size
//   exp_ct_o   expected ciphertext for that key and KAT_PT
module aes_kat_rom import aes_kat_pkg::*; (
  input  logic [LEN_W-1:0] len_sel_i,
  output logic [KEY_W-1:0] key_o,
  output logic [BLK_W-1:0] exp_ct_o
);

  // Pure table lookup; the unused size code maps to zero so nothing
  // meaningful can ever be checked against it.
  always_comb begin
    key_o    = '0;
    exp_ct_o = '0;
    case (len_sel_i)
      LEN_128: begin
        key_o    = KAT_KEY[0];
        exp_ct_o = KAT_CT[0];
      end
      LEN_192: begin
        key_o    = KAT_KEY[1];
        exp_ct_o = KAT_CT[1];
      end
      LEN_256: begin
        key_o    = KAT_KEY[2];
        exp_ct_o = KAT_CT[2];
      end
      default: begin
        key_o    = '0;
        exp_ct_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer
// Known-answer-test controller for the combinational AES cores. A start
// pulse walks through every key size enabled in SIZE_MASK: the key and
// plaintext are registered, the encrypt path gets SETTLE_CYC cycles, the
// ciphertext is captured and checked, the captured ciphertext is fed to the
// decryptor for another SETTLE_CYC cycles, and the recovered plaintext is
// checked. Results collect in sticky per-size pass/fail flags.
// Parameters:
//   SETTLE_CYC  settle budget for each combinational core path, 1..255
//   SIZE_MASK   bit i enables key size i (0=128, 1=192, 2=256)
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    aes_kat_sequencer_if.master (start, core results, key/data
//          drive, status and result flags)
module aes_kat_sequencer import aes_kat_pkg::*; #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [2:0]  SIZE_MASK  = 3'b111
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aes_kat_sequencer_if.master        bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  kat_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic             enc_ok_q, enc_ok_d;
  logic [2:0]       pass_q, pass_d;
  logic [2:0]       fail_q, fail_d;

  logic [KEY_W-1:0] rom_key;
  logic [BLK_W-1:0] rom_ct;
  logic [2:0]       first_sel;
  logic [2:0]       next_sel;
  logic [2:0]       len_onehot;
  logic             round_ok;

  aes_kat_rom u_rom (
    .len_sel_i (len_q),
    .key_o     (rom_key),
    .exp_ct_o  (rom_ct)
  );

  // Size walking and per-size result bookkeeping. The round-trip result only
  // counts when the encrypt was also correct, so a broken encryptor whose
  // output the decryptor happens to invert still shows up as a failure.
  assign first_sel  = next_enabled(SIZE_MASK, 3'd0);
  assign next_sel   = next_enabled(SIZE_MASK, {1'b0, len_q} + 3'd1);
  assign len_onehot = 3'b001 << len_q;
  assign round_ok   = enc_ok_q && (bus.dec_res_i == KAT_PT);

  // Next-state and datapath decode. Everything holds by default; each state
  // only touches the registers it owns. The wait states count the settle
  // counter down and leave on the cycle it reads zero, which gives exactly
  // SETTLE_CYC cycles of settling before each check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    key_d    = key_q;
    blk_d    = blk_q;
    ct_d     = ct_q;
    enc_ok_d = enc_ok_q;
    pass_d   = pass_q;
    fail_d   = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          pass_d = '0;
          fail_d = '0;
          if (first_sel[2]) begin
            len_d   = first_sel[1:0];
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_LOAD: begin
        key_d   = rom_key;
        blk_d   = KAT_PT;
        cnt_d   = SETTLE_LOAD;
        state_d = ST_ENC_WAIT;
      end

      ST_ENC_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ENC_CHK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_ENC_CHK: begin
        ct_d     = bus.enc_res_i;
        enc_ok_d = (bus.enc_res_i == rom_ct);
        cnt_d    = SETTLE_LOAD;
        state_d  = ST_DEC_WAIT;
      end

      ST_DEC_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DEC_CHK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DEC_CHK: begin
        pass_d = (pass_q & ~len_onehot) | (round_ok ? len_onehot : 3'b000);
        fail_d = (fail_q & ~len_onehot) | (round_ok ? 3'b000 : len_onehot);
        if (next_sel[2]) begin
          len_d   = next_sel[1:0];
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, so a reset in the
  // middle of a run simply abandons it without ever reaching DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      key_q    <= '0;
      blk_q    <= '0;
      ct_q     <= '0;
      enc_ok_q <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      key_q    <= key_d;
      blk_q    <= blk_d;
      ct_q     <= ct_d;
      enc_ok_q <= enc_ok_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  // Status is a straight decode of the state register, so it carries no
  // extra latency relative to the sequence itself.
  assign bus.busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done_o    = (state_q == ST_DONE);
  assign bus.len_sel_o = len_q;
  assign bus.key_o     = key_q;
  assign bus.blk_o     = blk_q;
  assign bus.ct_hold_o = ct_q;
  assign bus.pass_o    = pass_q;
  assign bus.fail_o    = fail_q;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// tb_aes_kat_sequencer
// Drives three sequencer instances (default config, 256-only with a one-cycle
// budget, and no sizes enabled) against behavioural AES core models. Each run
// pushes its expected outcome into a per-instance queue; a monitor pops and
// compares whenever an instance pulses done_o.
module tb_aes_kat_sequencer;

  localparam logic [127:0] TB_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] TB_K0  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] TB_K1  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] TB_K2  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] TB_CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] TB_CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] TB_CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    int           doneCycle;
    logic [2:0]   pass;
    logic [2:0]   fail;
    logic [127:0] ct;
    bit           ctCare;
    int           busyCycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   edgeCnt = 0;
  int   startMark [3] = '{0, 0, 0};
  int   busyCntA = 0, busyCntB = 0, busyCntC = 0;
  int   doneSeenA = 0;
  int   dlyA = 0;
  bit   bad192 = 1'b0;
  exp_t expQA [$];
  exp_t expQB [$];
  exp_t expQC [$];

  always #5 clk = ~clk;

  // Counts rising edges; run cycle numbers are measured against it.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  aes_kat_sequencer_if ifA ();
  aes_kat_sequencer_if ifB ();
  aes_kat_sequencer_if ifC ();

  aes_kat_sequencer dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.master));
  aes_kat_sequencer #(.SETTLE_CYC(1), .SIZE_MASK(3'b100))
    dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.master));
  aes_kat_sequencer #(.SETTLE_CYC(4), .SIZE_MASK(3'b000))
    dutC (.clk(clk), .rst_n(rst_n), .bus(ifC.master));

  // Golden encryptor: answers only for the exact FIPS key/plaintext pairs.
  // With bad192 set it returns a wrong ciphertext for the 192-bit key.
  function automatic logic [127:0] encModel(input logic [255:0] k,
                                            input logic [127:0] p, input bit b192);
    if (p != TB_PT) return ~p;
    if (k == TB_K0) return TB_CT0;
    if (k == TB_K1) return b192 ? (TB_CT1 ^ 128'h1) : TB_CT1;
    if (k == TB_K2) return TB_CT2;
    return ~p ^ k[255:128];
  endfunction

  // Golden decryptor, consistent with the (possibly broken) encryptor so a
  // wrong ciphertext still round-trips back to the plaintext.
  function automatic logic [127:0] decModel(input logic [255:0] k,
                                            input logic [127:0] c, input bit b192);
    if (k == TB_K0 && c == TB_CT0) return TB_PT;
    if (k == TB_K1 && c == (b192 ? (TB_CT1 ^ 128'h1) : TB_CT1)) return TB_PT;
    if (k == TB_K2 && c == TB_CT2) return TB_PT;
    return c ^ 128'hffff;
  endfunction

  // Instance A's cores can be given a latency of dlyA cycles through a
  // history of past results; histX[j] holds the value from j+1 cycles ago.
  logic [127:0] encNowA, decNowA;
  logic [127:0] encHistA [15];
  logic [127:0] decHistA [15];
  assign encNowA = encModel(ifA.key_o, ifA.blk_o, bad192);
  assign decNowA = decModel(ifA.key_o, ifA.ct_hold_o, bad192);

  always @(posedge clk) begin
    encHistA[0] <= encNowA;
    decHistA[0] <= decNowA;
    for (int k = 1; k < 15; k++) begin
      encHistA[k] <= encHistA[k-1];
      decHistA[k] <= decHistA[k-1];
    end
  end

  assign ifA.enc_res_i = (dlyA == 0) ? encNowA : encHistA[dlyA-1];
  assign ifA.dec_res_i = (dlyA == 0) ? decNowA : decHistA[dlyA-1];
  assign ifB.enc_res_i = encModel(ifB.key_o, ifB.blk_o, 1'b0);
  assign ifB.dec_res_i = decModel(ifB.key_o, ifB.ct_hold_o, 1'b0);
  assign ifC.enc_res_i = encModel(ifC.key_o, ifC.blk_o, 1'b0);
  assign ifC.dec_res_i = decModel(ifC.key_o, ifC.ct_hold_o, 1'b0);

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0:       return expQA.size();
      1:       return expQB.size();
      default: return expQC.size();
    endcase
  endfunction

  function automatic exp_t mkExp(input int cyc, input logic [2:0] p, input logic [2:0] f,
                                 input logic [127:0] c, input bit care, input int busy);
    exp_t e;
    e.doneCycle  = cyc;
    e.pass       = p;
    e.fail       = f;
    e.ct         = c;
    e.ctCare     = care;
    e.busyCycles = busy;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input exp_t e, input int cyc,
                             input logic [2:0] p, input logic [2:0] f,
                             input logic [127:0] c, input int busy);
    cmp({tag, " done cycle"}, 256'(cyc), 256'(e.doneCycle));
    cmp({tag, " pass_o"}, 256'(p), 256'(e.pass));
    cmp({tag, " fail_o"}, 256'(f), 256'(e.fail));
    cmp({tag, " busy cycles"}, 256'(busy), 256'(e.busyCycles));
    if (e.ctCare) cmp({tag, " ct_hold_o"}, 256'(c), 256'(e.ct));
  endtask

  task automatic scoreDone(input int idx, input string tag, input logic [2:0] p,
                           input logic [2:0] f, input logic [127:0] c, input int busy);
    exp_t e;
    if (qsize(idx) == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s unexpected done_o: got pulse want none", tag);
    end else begin
      case (idx)
        0:       e = expQA.pop_front();
        1:       e = expQB.pop_front();
        default: e = expQC.pop_front();
      endcase
      checkOutput(tag, e, edgeCnt - startMark[idx] + 1, p, f, c, busy);
    end
  endtask

  // Monitor: samples on the falling edge, tracks busy cycles per run and
  // scores each done_o pulse against the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busyCntA = 0;
      busyCntB = 0;
      busyCntC = 0;
    end else begin
      if (ifA.busy_o) busyCntA++;
      if (ifB.busy_o) busyCntB++;
      if (ifC.busy_o) busyCntC++;
      if (ifB.busy_o) cmp("B len_sel while busy", 256'(ifB.len_sel_o), 256'(2));
      if (ifA.done_o) begin
        doneSeenA++;
        scoreDone(0, "A", ifA.pass_o, ifA.fail_o, ifA.ct_hold_o, busyCntA);
        busyCntA = 0;
      end
      if (ifB.done_o) begin
        scoreDone(1, "B", ifB.pass_o, ifB.fail_o, ifB.ct_hold_o, busyCntB);
        busyCntB = 0;
      end
      if (ifC.done_o) begin
        scoreDone(2, "C", ifC.pass_o, ifC.fail_o, ifC.ct_hold_o, busyCntC);
        busyCntC = 0;
      end
    end
  end

  task automatic setStart(input int idx, input logic v);
    case (idx)
      0:       ifA.start_i = v;
      1:       ifB.start_i = v;
      default: ifC.start_i = v;
    endcase
  endtask

  // Pulses start for one cycle; returns at the falling edge of run cycle 1.
  task automatic applyStimulus(input int idx, input bit pushExp, input exp_t e);
    if (pushExp) begin
      case (idx)
        0:       expQA.push_back(e);
        1:       expQB.push_back(e);
        default: expQC.push_back(e);
      endcase
    end
    @(negedge clk);
    startMark[idx] = edgeCnt + 1;
    setStart(idx, 1'b1);
    @(negedge clk);
    setStart(idx, 1'b0);
  endtask

  task automatic waitRun(input int idx);
    for (int spins = 0; spins < 300 && qsize(idx) > 0; spins++) @(negedge clk);
    total++;
    if (qsize(idx) > 0) begin
      bad++;
      $display("[TB] FAIL run timeout dut%0d: got %0d pending want 0", idx, qsize(idx));
      case (idx)
        0:       expQA.delete();
        1:       expQB.delete();
        default: expQC.delete();
      endcase
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    cmp({tag, " len_sel_o"}, 256'(ifA.len_sel_o), 256'(0));
    cmp({tag, " key_o"}, ifA.key_o, 256'(0));
    cmp({tag, " blk_o"}, 256'(ifA.blk_o), 256'(0));
    cmp({tag, " ct_hold_o"}, 256'(ifA.ct_hold_o), 256'(0));
    cmp({tag, " busy_o"}, 256'(ifA.busy_o), 256'(0));
    cmp({tag, " done_o"}, 256'(ifA.done_o), 256'(0));
    cmp({tag, " pass_o"}, 256'(ifA.pass_o), 256'(0));
    cmp({tag, " fail_o"}, 256'(ifA.fail_o), 256'(0));
  endtask

  initial begin
    int doneBefore;
    ifA.start_i = 1'b0;
    ifB.start_i = 1'b0;
    ifC.start_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] default run, golden cores");
    applyStimulus(0, 1'b1, mkExp(34, 3'b111, 3'b000, TB_CT2, 1'b1, 33));
    waitRun(0);
    cmp("A key_o held", ifA.key_o, TB_K2);

    $display("[TB] 256-only, one-cycle budget");
    applyStimulus(1, 1'b1, mkExp(6, 3'b100, 3'b000, TB_CT2, 1'b1, 5));
    waitRun(1);
    cmp("B key_o held", ifB.key_o, TB_K2);
    cmp("B blk_o held", 256'(ifB.blk_o), 256'(TB_PT));

    $display("[TB] no sizes enabled");
    applyStimulus(2, 1'b1, mkExp(1, 3'b000, 3'b000, 128'h0, 1'b1, 0));
    waitRun(2);

    $display("[TB] wrong ciphertext for 192");
    bad192 = 1'b1;
    applyStimulus(0, 1'b1, mkExp(34, 3'b101, 3'b010, TB_CT2, 1'b1, 33));
    waitRun(0);
    bad192 = 1'b0;

    $display("[TB] cores with latency equal to the budget");
    dlyA = 4;
    repeat (20) @(negedge clk);
    applyStimulus(0, 1'b1, mkExp(34, 3'b111, 3'b000, TB_CT2, 1'b1, 33));
    waitRun(0);

    $display("[TB] cores one cycle slower than the budget");
    dlyA = 5;
    repeat (20) @(negedge clk);
    applyStimulus(0, 1'b1, mkExp(34, 3'b000, 3'b111, 128'h0, 1'b0, 33));
    waitRun(0);
    dlyA = 0;
    repeat (20) @(negedge clk);

    $display("[TB] start re-pulsed mid-run");
    applyStimulus(0, 1'b1, mkExp(34, 3'b111, 3'b000, TB_CT2, 1'b1, 33));
    repeat (9) @(negedge clk);
    ifA.start_i = 1'b1;
    @(negedge clk);
    ifA.start_i = 1'b0;
    waitRun(0);

    $display("[TB] reset mid-run");
    applyStimulus(0, 1'b0, mkExp(0, 3'b000, 3'b000, 128'h0, 1'b0, 0));
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("abort");
    rst_n = 1'b1;
    doneBefore = doneSeenA;
    repeat (60) @(negedge clk);
    cmp("no done after abort", 256'(doneSeenA), 256'(doneBefore));

    cmp("A queue drained", 256'(expQA.size()), 256'(0));
    cmp("B queue drained", 256'(expQB.size()), 256'(0));
    cmp("C queue drained", 256'(expQC.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
